memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/memory_controller.sv | 117 +++++++++++
 tb/tb_memory_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// Single-port word memory behind a three-state request/ack handshake with a
// programmable access latency and out-of-range address flagging.
module memory_controller #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              MEM_clk,
   input  logic              MEM_rst,
   input  logic              MEM_req,
   input  logic              MEM_wr,
   input  logic [15:0]       MEM_addr,
   input  logic [DATA_W-1:0] MEM_wdata,
   output logic [DATA_W-1:0] MEM_rdata,
   output logic              MEM_ack,
   output logic              MEM_err,
   output logic              MEM_busy
);

   // state  | meaning
   // IDLE   | waiting for MEM_req; inputs captured on accept
   // ACCESS | latency countdown; access performed when counter reaches 0
   // DONE   | one-cycle completion, MEM_ack high
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [15:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              mem_we;
   logic              in_range;

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // Upper address bits beyond the implemented depth must all be zero.
   assign in_range = ((addr_q >> ADDR_W) == 16'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (MEM_req) begin
               wr_d    = MEM_wr;
               addr_d  = MEM_addr;
               wdata_d = MEM_wdata;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               ack_d   = 1'b1;
               err_d   = !in_range;
               if (wr_q) begin
                  mem_we = in_range;
               end else begin
                  rdata_d = in_range ? mem_q[addr_q[ADDR_W-1:0]] : '0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge MEM_clk) begin
      if (MEM_rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 16'd0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Array is not reset; a reset at the access edge suppresses the write.
   always_ff @(posedge MEM_clk) begin
      if (mem_we && !MEM_rst) begin
         mem_q[addr_q[ADDR_W-1:0]] <= wdata_q;
      end
   end

   assign MEM_rdata = rdata_q;
   assign MEM_ack   = ack_q;
   assign MEM_err   = err_q;
   assign MEM_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: directed accesses on a WAIT_CYCLES=2
// instance plus latency checks on WAIT_CYCLES=1 and 5 instances.
module tb_memory_controller;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst, req, req_s, wr;
   logic [15:0] addr, wdata;
   logic [15:0] rdata, rdata1, rdata5;
   logic        ack, err, busy, ack1, err1, busy1, ack5, err5, busy5;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          cyc;
      logic        err;
      logic [15:0] rd;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   memory_controller #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W)) u_dut (
      .MEM_clk(clk), .MEM_rst(rst), .MEM_req(req), .MEM_wr(wr), .MEM_addr(addr),
      .MEM_wdata(wdata), .MEM_rdata(rdata), .MEM_ack(ack), .MEM_err(err), .MEM_busy(busy));

   memory_controller #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(1)) u_w1 (
      .MEM_clk(clk), .MEM_rst(rst), .MEM_req(req_s), .MEM_wr(wr), .MEM_addr(addr),
      .MEM_wdata(wdata), .MEM_rdata(rdata1), .MEM_ack(ack1), .MEM_err(err1), .MEM_busy(busy1));

   memory_controller #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(5)) u_w5 (
      .MEM_clk(clk), .MEM_rst(rst), .MEM_req(req_s), .MEM_wr(wr), .MEM_addr(addr),
      .MEM_wdata(wdata), .MEM_rdata(rdata5), .MEM_ack(ack5), .MEM_err(err5), .MEM_busy(busy5));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ack pops one expectation; err must never appear without ack.
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: got ack=1 expected no ack (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("ack_cycle", cyc, e.cyc);
            chk("ack_err", {31'd0, err}, {31'd0, e.err});
            chk("ack_rdata", {16'd0, rdata}, {16'd0, e.rd});
         end
      end else if (!rst) begin
         chk("err_without_ack", {31'd0, err}, 32'd0);
      end
   end

   // One access; returns in time for the next request to be accepted.
   task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic exp_err, input logic [15:0] exp_rd);
      @(negedge clk);
      wr = w; addr = a; wdata = d; req = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{cyc + W, exp_err, exp_rd});
      @(negedge clk);
      req = 1'b0; wr = ~w; addr = 16'hFFFF; wdata = 16'h5A5A;
      repeat (W) @(negedge clk);
   endtask

   int first1, first5, nack1, nack5, nbusy1, nbusy5;

   initial begin
      rst = 1'b1; req = 1'b0; req_s = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 16'h0;
      repeat (2) @(negedge clk);
      chk("rst_rdata", {16'd0, rdata}, 32'd0);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;

      issue(1'b1, 16'h0005, 16'h5555, 1'b0, 16'h0000);
      issue(1'b1, 16'h0000, 16'h0C0C, 1'b0, 16'h0000);
      issue(1'b1, 16'h0021, 16'h0000, 1'b0, 16'h0000);
      issue(1'b1, 16'h0012, 16'hBEEF, 1'b0, 16'h0000);
      issue(1'b0, 16'h0012, 16'h0000, 1'b0, 16'hBEEF);
      issue(1'b1, 16'h0100, 16'h1234, 1'b1, 16'hBEEF);
      issue(1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000);
      issue(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0C0C);

      // Continuous request with changing inputs: accepts at k = 0, 4, 8.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         req = 1'b1; wr = 1'b1; addr = 16'h0020 + 16'(k); wdata = 16'hA000 + 16'(k);
         @(posedge clk); #1;
         if (k % 4 == 0) sb.push_back('{cyc + W, 1'b0, 16'h0C0C});
      end
      @(negedge clk);
      req = 1'b0;
      issue(1'b0, 16'h0020, 16'h0000, 1'b0, 16'hA000);
      issue(1'b0, 16'h0024, 16'h0000, 1'b0, 16'hA004);
      issue(1'b0, 16'h0028, 16'h0000, 1'b0, 16'hA008);
      issue(1'b0, 16'h0021, 16'h0000, 1'b0, 16'h0000);

      // Reset abort at the edge that would have performed the write.
      @(negedge clk);
      wr = 1'b1; addr = 16'h0005; wdata = 16'hAAAA; req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ack", {31'd0, ack}, 32'd0);
      chk("abort_err", {31'd0, err}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rdata", {16'd0, rdata}, 32'd0);
      rst = 1'b0;
      issue(1'b0, 16'h0005, 16'h0000, 1'b0, 16'h5555);

      // Reset and request at the same edge.
      @(negedge clk);
      rst = 1'b1; req = 1'b1; wr = 1'b1; addr = 16'h0012; wdata = 16'hDEAD;
      @(negedge clk);
      chk("rst_prio_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0; req = 1'b0;
      @(negedge clk);
      chk("rst_prio_idle", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      issue(1'b0, 16'h0012, 16'h0000, 1'b0, 16'hBEEF);

      // Latency sweep on the WAIT_CYCLES=1 and 5 instances.
      first1 = -1; first5 = -1; nack1 = 0; nack5 = 0; nbusy1 = 0; nbusy5 = 0;
      @(negedge clk);
      req_s = 1'b1; wr = 1'b1; addr = 16'h0003; wdata = 16'h0007;
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         req_s = 1'b0;
         if (ack1 === 1'b1) begin nack1++; if (first1 < 0) first1 = i; end
         if (ack5 === 1'b1) begin nack5++; if (first5 < 0) first5 = i; end
         if (busy1 === 1'b1) nbusy1++;
         if (busy5 === 1'b1) nbusy5++;
      end
      chk("w1_latency", first1, 1);
      chk("w5_latency", first5, 5);
      chk("w1_ack_width", nack1, 1);
      chk("w5_ack_width", nack5, 1);
      chk("w1_busy_cycles", nbusy1, 2);
      chk("w5_busy_cycles", nbusy5, 6);

      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
